// File: rtl/wta_disparity_select_pkg.sv
// Shared depth-pipeline constants for the winner-take-all disparity stage.
package wta_disparity_select_pkg;

  localparam int COST_W_DEF      = 9;   // adder sum width: 8-bit operands plus carry
  localparam int NUM_DISP_DEF    = 16;
  localparam int DISP_W_DEF      = 4;   // clog2(NUM_DISP_DEF)
  localparam int UNIQ_MARGIN_DEF = 4;

  // Largest representable cost; used as the "no candidate yet" value.
  localparam logic [COST_W_DEF-1:0] COST_MAX = '1;

endpackage

// File: rtl/wta_min2_update.sv
// One-beat best/second-best update. Strict less-than keeps the lower
// disparity on ties, so the first occurrence of the minimum wins.
module wta_min2_update
  import wta_disparity_select_pkg::*;
#(
  parameter int COST_W = COST_W_DEF,
  parameter int DISP_W = DISP_W_DEF
) (
  input  logic              first,
  input  logic [DISP_W-1:0] disp,
  input  logic [COST_W-1:0] cost,
  input  logic [COST_W-1:0] best,
  input  logic [COST_W-1:0] second,
  input  logic [DISP_W-1:0] best_d,
  output logic [COST_W-1:0] best_nxt,
  output logic [COST_W-1:0] second_nxt,
  output logic [DISP_W-1:0] best_d_nxt
);

  // Fold one cost into the running minimum pair.
  always_comb begin
    best_nxt   = best;
    second_nxt = second;
    best_d_nxt = best_d;
    if (first) begin
      best_nxt   = cost;
      second_nxt = '1;
      best_d_nxt = '0;
    end else if (cost < best) begin
      second_nxt = best;
      best_nxt   = cost;
      best_d_nxt = disp;
    end else if (cost < second) begin
      second_nxt = cost;
    end
  end

endmodule

// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity select: consumes NUM_DISP serial costs per
// pixel and presents the winning disparity, its cost and a uniqueness flag
// on a valid/ready output. The output register is single-entry, so new
// beats are held off while an unconsumed result is blocked downstream.
module wta_disparity_select
  import wta_disparity_select_pkg::*;
#(
  parameter int COST_W      = COST_W_DEF,
  parameter int NUM_DISP    = NUM_DISP_DEF,
  parameter int DISP_W      = DISP_W_DEF,
  parameter int UNIQ_MARGIN = UNIQ_MARGIN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cost_valid,
  input  logic              cost_sop,
  input  logic [COST_W-1:0] cost_in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] disp_out,
  output logic [COST_W-1:0] cost_out,
  output logic              unique_out,
  output logic              sync_err
);

  localparam logic [DISP_W-1:0] LAST_D = DISP_W'(NUM_DISP - 1);
  localparam logic [COST_W-1:0] MARGIN = COST_W'(UNIQ_MARGIN);

  logic [DISP_W-1:0] disp_cnt;
  logic [DISP_W-1:0] best_d;
  logic [DISP_W-1:0] best_d_nxt;
  logic [DISP_W-1:0] k_eff;
  logic [COST_W-1:0] best;
  logic [COST_W-1:0] second;
  logic [COST_W-1:0] best_nxt;
  logic [COST_W-1:0] second_nxt;
  logic [COST_W-1:0] spread;
  logic              accept;
  logic              first_beat;
  logic              last_beat;
  logic              misaligned;

  assign in_ready   = ~(out_valid & ~out_ready);
  assign accept     = cost_valid & in_ready;
  // An SOP always restarts the pixel, wherever the counter happens to be.
  assign k_eff      = cost_sop ? '0 : disp_cnt;
  assign first_beat = (k_eff == '0);
  assign last_beat  = accept & (k_eff == LAST_D);
  assign misaligned = cost_sop ^ (disp_cnt == '0);
  // second >= best always holds, so this never wraps.
  assign spread     = second_nxt - best_nxt;

  wta_min2_update #(
    .COST_W (COST_W),
    .DISP_W (DISP_W)
  ) u_min2 (
    .first      (first_beat),
    .disp       (k_eff),
    .cost       (cost_in),
    .best       (best),
    .second     (second),
    .best_d     (best_d),
    .best_nxt   (best_nxt),
    .second_nxt (second_nxt),
    .best_d_nxt (best_d_nxt)
  );

  // Beat counter and running minimum pair; frozen while no beat is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_cnt <= '0;
      best     <= '1;
      second   <= '1;
      best_d   <= '0;
    end else if (accept) begin
      disp_cnt <= (k_eff == LAST_D) ? '0 : k_eff + 1'b1;
      best     <= best_nxt;
      second   <= second_nxt;
      best_d   <= best_d_nxt;
    end
  end

  // Result registers: load on the last beat, otherwise drop valid once consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      disp_out   <= '0;
      cost_out   <= '0;
      unique_out <= 1'b0;
    end else if (last_beat) begin
      out_valid  <= 1'b1;
      disp_out   <= best_d_nxt;
      cost_out   <= best_nxt;
      unique_out <= (spread >= MARGIN);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky SOP misalignment flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_err <= 1'b0;
    end else if (accept && misaligned) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wta_disparity_select.sv
// Bench for wta_disparity_select: directed pixels with hand-computed
// results, then randomized pixels with SOP faults and random backpressure,
// all checked every cycle against a queue-based reference model.
module tb_wta_disparity_select;

  localparam int COST_W      = 9;
  localparam int NUM_DISP    = 16;
  localparam int DISP_W      = 4;
  localparam int UNIQ_MARGIN = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cost_valid;
  logic              cost_sop;
  logic [COST_W-1:0] cost_in;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DISP_W-1:0] disp_out;
  logic [COST_W-1:0] cost_out;
  logic              unique_out;
  logic              sync_err;

  int  ready_mode;   // 0: always ready, 1: random, 2: never ready
  bit  rnd_ready;
  bit  chk_en;
  int  total;
  int  bad;

  logic [COST_W-1:0] pixbuf [NUM_DISP];

  // Reference model state
  int unsigned pix [$];
  bit          mv;
  int          mdisp;
  int          mcost;
  bit          muniq;
  bit          merr;
  bit          m_acc;
  bit          m_done;
  bit          m_in_ready;

  assign out_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : rnd_ready;
  assign m_in_ready = !(mv && !out_ready);

  wta_disparity_select #(
    .COST_W      (COST_W),
    .NUM_DISP    (NUM_DISP),
    .DISP_W      (DISP_W),
    .UNIQ_MARGIN (UNIQ_MARGIN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cost_valid (cost_valid),
    .cost_sop   (cost_sop),
    .cost_in    (cost_in),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .disp_out   (disp_out),
    .cost_out   (cost_out),
    .unique_out (unique_out),
    .sync_err   (sync_err)
  );

  always #5 clock = ~clock;

  // Random downstream readiness, changed just after each rising edge.
  always @(posedge clock) begin
    #1;
    rnd_ready = ($urandom_range(0, 1) == 1);
  end

  // Reference model: collect the costs of the current pixel, pick the winner
  // by searching the whole pixel when it completes.
  always @(posedge clock) begin
    if (reset) begin
      pix.delete();
      mv = 0; mdisp = 0; mcost = 0; muniq = 0; merr = 0;
    end else begin
      m_acc  = cost_valid && m_in_ready;
      m_done = 0;
      if (m_acc) begin
        if (cost_sop != (pix.size() == 0)) merr = 1;
        if (cost_sop) pix.delete();
        pix.push_back(int'(cost_in));
        if (pix.size() == NUM_DISP) begin
          int bi;
          int unsigned sec;
          bi  = 0;
          for (int i = 1; i < NUM_DISP; i++)
            if (pix[i] < pix[bi]) bi = i;
          sec = (1 << COST_W) - 1;
          for (int j = 0; j < NUM_DISP; j++)
            if (j != bi && pix[j] < sec) sec = pix[j];
          mdisp  = bi;
          mcost  = int'(pix[bi]);
          muniq  = ((sec - pix[bi]) >= UNIQ_MARGIN);
          m_done = 1;
          pix.delete();
        end
      end
      if (m_done) mv = 1;
      else if (out_ready) mv = 0;
    end
  end

  task automatic check_lit(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Present one beat and hold it until the stage takes it.
  task automatic beat(input logic [COST_W-1:0] c, input bit s);
    int n;
    n = 0;
    cost_valid = 1'b1;
    cost_in    = c;
    cost_sop   = s;
    @(negedge clock);
    while (!m_in_ready) begin
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: beat not accepted after %0d cycles", n);
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    cost_valid = 1'b0;
    cost_sop   = 1'b0;
    cost_in    = COST_W'($urandom);
  endtask

  task automatic send_pixbuf();
    for (int k = 0; k < NUM_DISP; k++) beat(pixbuf[k], k == 0);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (chk_en) begin
        total += 3;
        if (in_ready !== m_in_ready) begin
          bad++; $display("FAIL in_ready: got %b expected %b at %0t", in_ready, m_in_ready, $time);
        end
        if (out_valid !== mv) begin
          bad++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, mv, $time);
        end
        if (sync_err !== merr) begin
          bad++; $display("FAIL sync_err: got %b expected %b at %0t", sync_err, merr, $time);
        end
        if (mv) begin
          total++;
          if (disp_out !== DISP_W'(mdisp) || cost_out !== COST_W'(mcost) || unique_out !== muniq) begin
            bad++;
            $display("FAIL result: got d=%0d c=%0d u=%b expected d=%0d c=%0d u=%b at %0t",
                     disp_out, cost_out, unique_out, mdisp, mcost, muniq, $time);
          end
        end
      end
    end
  endtask

  task automatic main_seq();
    reset = 1'b1; cost_valid = 1'b0; cost_sop = 1'b0; cost_in = '0; ready_mode = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clock);
    check_lit("rst_out_valid", out_valid, 0);
    check_lit("rst_in_ready", in_ready, 1);
    check_lit("rst_disp", disp_out, 0);
    check_lit("rst_cost", cost_out, 0);
    check_lit("rst_unique", unique_out, 0);
    check_lit("rst_sync_err", sync_err, 0);
    @(posedge clock); #1;

    // Descending costs: last disparity wins by one.
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = COST_W'(100 - k);
    send_pixbuf();
    @(negedge clock);
    check_lit("desc_valid", out_valid, 1);
    check_lit("desc_disp", disp_out, 15);
    check_lit("desc_cost", cost_out, 85);
    check_lit("desc_unique", unique_out, 0);
    check_lit("desc_model_disp", mdisp, 15);
    @(posedge clock); #1;

    // Single dip at k=7.
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = (k == 7) ? 9'd20 : 9'd50;
    send_pixbuf();
    @(negedge clock);
    check_lit("dip_disp", disp_out, 7);
    check_lit("dip_cost", cost_out, 20);
    check_lit("dip_unique", unique_out, 1);
    @(posedge clock); #1;

    // All equal: tie keeps disparity 0.
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = 9'd30;
    send_pixbuf();
    @(negedge clock);
    check_lit("tie_disp", disp_out, 0);
    check_lit("tie_cost", cost_out, 30);
    check_lit("tie_unique", unique_out, 0);
    check_lit("tie_model_unique", int'(muniq), 0);
    @(posedge clock); #1;

    // Backpressure: hold the first result, second pixel must wait.
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = COST_W'(10 + 2 * k);
    send_pixbuf();
    ready_mode = 2;
    @(negedge clock);
    check_lit("bp_disp", disp_out, 0);
    check_lit("bp_cost", cost_out, 10);
    check_lit("bp_unique", unique_out, 0);
    fork
      begin
        for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = COST_W'($urandom_range(0, 511));
        send_pixbuf();
      end
      begin
        repeat (10) @(negedge clock);
        check_lit("bp_in_ready", in_ready, 0);
        check_lit("bp_hold_valid", out_valid, 1);
        check_lit("bp_hold_cost", cost_out, 10);
        @(posedge clock); #1;
        ready_mode = 0;
      end
    join
    @(posedge clock); #1;

    // Mid-pixel SOP: the five cheap partial beats must be discarded.
    for (int k = 0; k < 5; k++) beat(9'd1, k == 0);
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = (k == 3) ? 9'd7 : 9'd60;
    send_pixbuf();
    @(negedge clock);
    check_lit("sop_sync_err", sync_err, 1);
    check_lit("sop_disp", disp_out, 3);
    check_lit("sop_cost", cost_out, 7);
    check_lit("sop_unique", unique_out, 1);
    @(posedge clock); #1;

    // Reset mid-pixel, then a clean pixel.
    for (int k = 0; k < 9; k++) beat(9'd5, k == 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_lit("rstmid_valid", out_valid, 0);
    check_lit("rstmid_sync_err", sync_err, 0);
    @(posedge clock); #1;
    for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = (k == 2) ? 9'd3 : 9'd40;
    send_pixbuf();
    @(negedge clock);
    check_lit("clean_disp", disp_out, 2);
    check_lit("clean_cost", cost_out, 3);
    check_lit("clean_sync_err", sync_err, 0);
    @(posedge clock); #1;

    // Back-to-back pixels with downstream always ready.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < NUM_DISP; k++) pixbuf[k] = COST_W'($urandom_range(0, 63));
      send_pixbuf();
    end

    // Randomized pixels, SOP faults, idle gaps and random backpressure.
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int rng;
      bit s;
      case ($urandom_range(0, 2))
        0:       rng = 3;
        1:       rng = 15;
        default: rng = 511;
      endcase
      for (int k = 0; k < NUM_DISP; k++) begin
        s = (k == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) == 0);
        beat(COST_W'($urandom_range(0, rng)), s);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clock); #1;
        end
      end
    end
    ready_mode = 0;
    repeat (5) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    chk_en = 0;
    fork
      compare_loop();
      main_seq();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
